// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - echoes every received UART byte back through uart_tx
// Circular byte FIFO drained by a three-state issue FSM paced by the transmitter's active/done handshake.
module uart_echo_responder #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          source_clk,
    input  logic          i_rst,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_byte,
    output logic          o_tx_valid,
    output logic [7:0]    o_tx_message,
    input  logic          i_tx_active,
    input  logic          i_tx_done,
    output logic [CW-1:0] o_count,
    output logic          o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          issue;
    logic          push;
    logic          pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pop     = issue;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push    = i_rx_valid && (!full || pop);
    assign o_count = count;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !i_tx_active) begin
                    issue      = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (i_tx_done) begin
                    state_next = IDLE;
                end else if (i_tx_active) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done || !i_tx_active) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge source_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge source_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_rx_byte;
        end
    end

    always_ff @(posedge source_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge source_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx_valid   <= 1'b0;
            o_tx_message <= 8'h00;
            o_overflow   <= 1'b0;
        end else begin
            o_tx_valid <= issue;
            if (issue) begin
                o_tx_message <= mem[rd_ptr];
            end
            if (i_rx_valid && full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - scoreboard bench for uart_echo_responder
// Stimulus pushes expected bytes into a queue model; a monitor pops and compares on every issue.
module tb_uart_echo_responder;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          source_clk;
    logic          i_rst;
    logic          i_rx_valid;
    logic [7:0]    i_rx_byte;
    logic          o_tx_valid;
    logic [7:0]    o_tx_message;
    logic          i_tx_active;
    logic          i_tx_done;
    logic [CW-1:0] o_count;
    logic          o_overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         m_count   = 0;
    logic       m_ovf     = 1'b0;
    logic       prev_pop  = 1'b0;
    logic [7:0] last_msg  = 8'h00;

    int   busy        = 0;
    int   frame_len   = 20;
    logic rand_frames = 1'b0;
    logic force_active = 1'b0;

    uart_echo_responder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .source_clk   (source_clk),
        .i_rst        (i_rst),
        .i_rx_valid   (i_rx_valid),
        .i_rx_byte    (i_rx_byte),
        .o_tx_valid   (o_tx_valid),
        .o_tx_message (o_tx_message),
        .i_tx_active  (i_tx_active),
        .i_tx_done    (i_tx_done),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    initial source_clk = 1'b0;
    always #5 source_clk = ~source_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge source_clk);
        #2;
    endtask

    // uart_tx stand-in: goes active after each start pulse, then pulses done at the end of the frame.
    initial begin
        i_tx_active = 1'b0;
        i_tx_done   = 1'b0;
        forever begin
            @(negedge source_clk);
            #1;
            i_tx_done = 1'b0;
            if (o_tx_valid) begin
                busy = rand_frames ? int'($urandom_range(1, 25)) : frame_len;
            end
            if (busy > 0) begin
                busy--;
                if (busy == 0) i_tx_done = 1'b1;
            end
            i_tx_active = force_active || (busy > 0);
        end
    end

    // Scoreboard monitor: inputs sampled at the edge, outputs checked just after it.
    initial begin
        logic       s_push;
        logic [7:0] s_byte;
        logic       s_active;
        logic       s_rst;
        logic       pop;
        forever begin
            @(posedge source_clk);
            s_push   = i_rx_valid;
            s_byte   = i_rx_byte;
            s_active = i_tx_active;
            s_rst    = i_rst;
            #1;
            if (s_rst || i_rst) begin
                exp_q.delete();
                m_count  = 0;
                m_ovf    = 1'b0;
                prev_pop = 1'b0;
                last_msg = 8'h00;
            end else begin
                pop = o_tx_valid;
                if (pop) begin
                    chk("issue_while_active", s_active, 1'b0);
                    chk("valid_one_cycle", prev_pop, 1'b0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_issue", 1, 0);
                    end else begin
                        chk("tx_message", o_tx_message, exp_q.pop_front());
                    end
                    last_msg = o_tx_message;
                end else begin
                    chk("message_held", o_tx_message, last_msg);
                end
                if (s_push) begin
                    if (m_count < DEPTH || pop) begin
                        exp_q.push_back(s_byte);
                        if (!pop) m_count++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (pop) begin
                    m_count--;
                end
                chk("count", o_count, m_count);
                chk("overflow", o_overflow, m_ovf);
                prev_pop = pop;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        step();
        i_rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy != 0 || i_tx_active) && n < 3000) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 3000, 1);
        step();
        step();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int peak;
        int n;
        i_rst      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_byte  = 8'h00;
        step();
        chk("reset_count", o_count, 0);
        chk("reset_valid", o_tx_valid, 0);
        chk("reset_message", o_tx_message, 8'h00);
        chk("reset_overflow", o_overflow, 0);
        step();
        i_rst = 1'b0;
        step();

        // Single byte: issue one cycle after the push edge.
        push_byte(8'hAB);
        chk("single_count_after_push", o_count, 1);
        chk("single_valid_early", o_tx_valid, 0);
        step();
        chk("single_valid", o_tx_valid, 1);
        chk("single_message", o_tx_message, 8'hAB);
        chk("single_count_after_pop", o_count, 0);
        step();
        chk("single_valid_pulse", o_tx_valid, 0);
        drain();

        // Burst of five behind a 20-cycle frame.
        frame_len = 20;
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            i_rx_valid = 1'b1;
            i_rx_byte  = 8'(i);
            step();
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        i_rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        chk("burst_peak", (peak == 4 || peak == 5), 1);
        drain();

        // Overflow with the transmitter held busy.
        force_active = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            i_rx_valid = 1'b1;
            i_rx_byte  = 8'(8'h10 + i);
            step();
        end
        i_rx_valid = 1'b0;
        step();
        chk("ovf_count", o_count, 16);
        chk("ovf_flag", o_overflow, 1);
        force_active = 1'b0;
        drain();
        chk("ovf_sticky", o_overflow, 1);

        // Push and pop together at full.
        do_reset();
        force_active = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            i_rx_valid = 1'b1;
            i_rx_byte  = 8'(8'h40 + i);
            step();
        end
        i_rx_valid   = 1'b0;
        force_active = 1'b0;
        step();
        push_byte(8'h77);
        chk("full_pushpop_issue", o_tx_valid, 1);
        chk("full_pushpop_count", o_count, 16);
        chk("full_pushpop_overflow", o_overflow, 0);
        drain();

        // Reset while the transmitter is mid-frame with bytes queued.
        frame_len = 40;
        push_byte(8'h31);
        n = 0;
        while (!i_tx_active && n < 20) begin
            step();
            n++;
        end
        chk("wait_active_timeout", n < 20, 1);
        push_byte(8'h32);
        push_byte(8'h33);
        push_byte(8'h34);
        chk("queued_count", o_count, 3);
        i_rst = 1'b1;
        #1;
        chk("rst_count", o_count, 0);
        chk("rst_valid", o_tx_valid, 0);
        chk("rst_message", o_tx_message, 8'h00);
        chk("rst_overflow", o_overflow, 0);
        step();
        i_rst = 1'b0;
        chk("still_active_after_rst", i_tx_active, 1);
        push_byte(8'h5A);
        drain();

        // Randomized traffic with random frame lengths.
        rand_frames = 1'b1;
        for (int i = 0; i < 400; i++) begin
            i_rx_valid = ($urandom_range(0, 3) == 0);
            i_rx_byte  = 8'($urandom);
            step();
        end
        i_rx_valid = 1'b0;
        drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_count", o_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

- Receive-side responder sitting between `uart_rx` and `uart_tx`.
- Buffers every byte from `uart_rx` in a small FIFO and re-issues it, in order, to `uart_tx`.
- Paces each byte with the `uart_tx` active/done handshake.
- Forms the remote end of the loopback path: a host sending bytes over the serial line gets the same bytes echoed back.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CW, 5, count width; must equal log2(DEPTH)+1.

Ports:
- source_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_rx_valid  input  1  one-cycle pulse from `uart_rx` `o_rx_valid`.
- i_rx_byte  input  8  from `uart_rx` `o_RX_message`; valid when i_rx_valid=1.
- o_tx_valid  output  1  one-cycle start pulse to `uart_tx` `i_tx_valid`.
- o_tx_message  output  8  byte to `uart_tx` `tx_message`; held stable from the o_tx_valid cycle until the next issue.
- i_tx_active  input  1  `uart_tx` `tx_active`.
- i_tx_done  input  1  `uart_tx` `done` pulse.
- o_count  output  CW  current FIFO occupancy, 0..DEPTH.
- o_overflow  output  1  sticky: a byte was dropped because the FIFO was full.

## Operation
FIFO:
- Circular buffer with wr_ptr and rd_ptr (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and a count register.
- Push on i_rx_valid when count<DEPTH.
- Pop when the FSM issues a byte.
- Push and pop in the same cycle: both occur and count is unchanged. This holds even at count=DEPTH, where the push is accepted.
- Push at count=DEPTH with no pop: byte discarded, pointers unchanged, o_overflow set to 1 until reset.
- empty = (count==0). The FIFO is never read when empty.

Issue FSM (registered states):
- IDLE: if !empty and !i_tx_active, load o_tx_message from the FIFO head, pulse o_tx_valid, pop, and go to WAIT_BUSY. Otherwise stay.
- WAIT_BUSY: wait for i_tx_active=1, then go to WAIT_DONE. If i_tx_done=1 arrives first, go straight to IDLE.
- WAIT_DONE: on i_tx_done=1, or i_tx_active=0, go to IDLE.
- Undefined state encodings return to IDLE.
- Bytes go out strictly in arrival order; no byte is duplicated or reordered.

Reset (asynchronous, takes effect immediately):
- FSM -> IDLE.
- Pointers and count -> 0; FIFO contents are dropped.
- o_tx_valid=0, o_tx_message=8'h00, o_count=0, o_overflow=0.
- Reset during WAIT_DONE does not affect `uart_tx`. After release the FSM waits in IDLE until i_tx_active=0 before issuing.

## Timing
- All outputs are registered.
- Latency: with the FIFO empty and the FSM in IDLE, if i_rx_valid is sampled at edge E0, o_tx_valid is high for exactly one cycle after edge E1, carrying that byte.
- o_count reflects a push or pop one cycle after the edge that performs it.
- Minimum spacing between o_tx_valid pulses is 3 cycles. In practice spacing is set by the `uart_tx` frame time (10 bit periods).
- o_tx_valid is never asserted while i_tx_active=1 or while in WAIT_BUSY/WAIT_DONE.
- i_rx_valid may arrive in any FSM state and in consecutive cycles; each pulse is one push attempt.

## Test plan
- Single byte: i_rx_valid with 8'hAB, FSM idle -> o_tx_valid one cycle after E1, o_tx_message=8'hAB, o_count 1 -> 0.
- Burst, with a stub `uart_tx` model holding i_tx_active high for 20 cycles and then pulsing done: 8'h01..8'h05 on consecutive cycles -> o_count peaks at 4 or 5; issues are 01,02,03,04,05 in order; no o_tx_valid while active.
- Overflow with DEPTH=16, i_tx_active held 1: push 17 bytes 8'h10..8'h20 -> o_count=16, o_overflow=1; after release, output is 10..1F and 8'h20 is lost.
- Simultaneous push/pop at full: count=16, i_rx_valid asserted in the same cycle as the IDLE issue -> o_count stays 16, o_overflow stays 0.
- Reset mid-operation: assert i_rst with 3 bytes queued during WAIT_DONE -> all outputs 0 immediately; no issue until i_tx_active=0; subsequent byte 8'h5A is echoed correctly.
- Full loopback with real `uart_rx`/`uart_tx` at 10 MHz, 9600 baud: a host model serially sends 8'hAB, 8'h00, 8'hFF -> the echoed serial line carries the same three bytes, decoded by a second `uart_rx`.
